yari_pipectl: RTL

YARI_PIPECTL -- requirements
Module: yari_pipectl

---
 rtl/yari_pkg.sv | 18 +
 rtl/pipectl_prio.sv | 31 +++
 rtl/yari_pipectl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/yari_pkg.sv
// Shared definitions for the yari pipeline controller.
// Holds the controller state encoding and the default vectors and widths.
// No logic lives here; the default vectors can be overridden per instance.
package yari_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_BOOT   = 2'd1,
    ST_RUN    = 2'd2,
    ST_MASKED = 2'd3
  } state_t;

  localparam int          DEF_PCW     = 32;
  localparam logic [31:0] DEF_BOOT_PC = 32'hBFC0_0000;
  localparam logic [31:0] DEF_IRQ_PC  = 32'h8000_0180;
  localparam int          RCNT_W      = 16;

endpackage

// File: rtl/pipectl_prio.sv
// Highest-index restart select: the winning stage's PC and the mask of younger stages to squash.
// Purely combinational, zero latency.
// No backpressure; the result follows the request bits in the same cycle.
module pipectl_prio #(
  parameter int STAGES = 4,
  parameter int PCW    = 32
) (
  input  logic [STAGES-1:0]     i_req,
  input  logic [STAGES*PCW-1:0] i_pc,
  output logic                  o_any,
  output logic [PCW-1:0]        o_pc,
  output logic [STAGES-1:0]     o_flush
);

  // Walk from the youngest up; the last set bit seen is the oldest requester and wins.
  always_comb begin
    o_any   = 1'b0;
    o_pc    = '0;
    o_flush = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (i_req[k]) begin
        o_any = 1'b1;
        o_pc  = i_pc[k*PCW +: PCW];
        for (int j = 0; j < STAGES; j++) begin
          o_flush[j] = (j < k);
        end
      end
    end
  end

endmodule

// File: rtl/yari_pipectl.sv
// Pipeline control: boot sequencing, stage restarts and interrupt take for a fetch redirect.
// Redirect/flush are combinational (zero latency); irq_ack and epc update one edge after a take.
// No backpressure; kill holds fetch idle through the boot delay and the boot redirect.
module yari_pipectl
  import yari_pkg::*;
#(
  parameter int             STAGES     = 4,
  parameter int             BOOT_DELAY = 8,
  parameter int             PCW        = DEF_PCW,
  parameter logic [PCW-1:0] BOOT_PC    = PCW'(DEF_BOOT_PC),
  parameter logic [PCW-1:0] IRQ_PC     = PCW'(DEF_IRQ_PC)
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [STAGES-1:0]     stage_restart,
  input  logic [STAGES*PCW-1:0] stage_restart_pc,
  input  logic                  oldest_valid,
  input  logic [PCW-1:0]        oldest_pc,
  input  logic                  irq_req,
  input  logic                  irq_enable,
  output logic                  kill,
  output logic                  restart,
  output logic [PCW-1:0]        restart_pc,
  output logic [STAGES-1:0]     flush,
  output logic                  irq_ack,
  output logic [PCW-1:0]        epc,
  output logic                  booted,
  output logic [RCNT_W-1:0]     restart_count
);

  localparam int CW = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_dly;
  logic                r_irq_ack;
  logic [PCW-1:0]      r_epc;
  logic [RCNT_W-1:0]   r_rcnt;

  logic                w_any;
  logic [PCW-1:0]      w_sel_pc;
  logic [STAGES-1:0]   w_sel_flush;
  logic                w_take;

  pipectl_prio #(
    .STAGES (STAGES),
    .PCW    (PCW)
  ) u_prio (
    .i_req   (stage_restart),
    .i_pc    (stage_restart_pc),
    .o_any   (w_any),
    .o_pc    (w_sel_pc),
    .o_flush (w_sel_flush)
  );

  // Next state and redirect outputs; rst overrides everything so an in-flight boot or take is dropped.
  always_comb begin
    w_state_nxt = r_state;
    kill        = 1'b1;
    restart     = 1'b0;
    restart_pc  = '0;
    flush       = '0;
    w_take      = 1'b0;
    case (r_state)
      ST_RESET: begin
        if (r_dly == CW'(BOOT_DELAY - 1)) w_state_nxt = ST_BOOT;
      end
      ST_BOOT: begin
        restart     = 1'b1;
        restart_pc  = BOOT_PC;
        flush       = '1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        kill = 1'b0;
        if (w_any) begin
          restart    = 1'b1;
          restart_pc = w_sel_pc;
          flush      = w_sel_flush;
        end else if (irq_req && irq_enable && oldest_valid) begin
          // A stage restart in the same cycle wins; a held request is retaken next cycle.
          w_take      = 1'b1;
          restart     = 1'b1;
          restart_pc  = IRQ_PC;
          flush       = '1;
          w_state_nxt = ST_MASKED;
        end
      end
      ST_MASKED: begin
        kill = 1'b0;
        if (w_any) begin
          restart    = 1'b1;
          restart_pc = w_sel_pc;
          flush      = w_sel_flush;
        end
        if (!irq_enable) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RESET;
    endcase
    if (rst) begin
      w_state_nxt = ST_RESET;
      kill        = 1'b1;
      restart     = 1'b0;
      restart_pc  = '0;
      flush       = '0;
      w_take      = 1'b0;
    end
  end

  // State, boot delay counter, interrupt capture and saturating restart counter.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state   <= ST_RESET;
      r_dly     <= '0;
      r_irq_ack <= 1'b0;
      r_epc     <= '0;
      r_rcnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_RESET && w_state_nxt == ST_RESET) r_dly <= r_dly + 1'b1;
      else                                                r_dly <= '0;
      r_irq_ack <= w_take;
      if (w_take) r_epc <= oldest_pc;
      if (restart && r_rcnt != '1) r_rcnt <= r_rcnt + 1'b1;
    end
  end

  assign irq_ack       = r_irq_ack & ~rst;
  assign epc           = rst ? '0 : r_epc;
  assign restart_count = rst ? '0 : r_rcnt;
  assign booted        = ~rst & ((r_state == ST_RUN) || (r_state == ST_MASKED));

endmodule
